// File: rtl/tcu_priv_pmpfail_collect_pkg.sv
// tcu_priv_pmpfail_collect_pkg: shared TCU sizes, PMP-failure record layout and packing helper
package tcu_priv_pmpfail_collect_pkg;

    localparam int TCU_PHYSADDR_SIZE         = 32;
    localparam int TCU_ERROR_SIZE            = 5;
    localparam int TCU_CORE_REQ_PMPFAIL_SIZE = TCU_PHYSADDR_SIZE + TCU_ERROR_SIZE + 1;

    // Field offsets inside the record; the core-request unit decodes with the same layout.
    localparam int PMPFAIL_WRITE_BIT = 0;
    localparam int PMPFAIL_ERROR_LSB = 1;
    localparam int PMPFAIL_ADDR_LSB  = TCU_ERROR_SIZE + 1;

    typedef logic [TCU_CORE_REQ_PMPFAIL_SIZE-1:0] pmpfail_t;

    function automatic pmpfail_t pack_pmpfail(
        input logic [TCU_PHYSADDR_SIZE-1:0] addr,
        input logic [TCU_ERROR_SIZE-1:0]    error,
        input logic                         write
    );
        return {addr, error, write};
    endfunction

endpackage

// File: rtl/tcu_priv_pmpfail_collect_arbiter.sv
// tcu_rr_arbiter: round-robin arbiter with a registered priority pointer
module tcu_rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk_i,
    input  logic         reset_n_i,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant_onehot
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_next_ptr;
    logic          w_found;

    // Search from the pointer upward, wrapping, and pick the first requester.
    always_comb begin
        grant_onehot = '0;
        w_found      = 1'b0;
        w_next_ptr   = r_ptr;
        for (int i = 0; i < N; i++) begin
            if (!w_found && req[(int'(r_ptr) + i) % N]) begin
                grant_onehot[(int'(r_ptr) + i) % N] = 1'b1;
                w_found    = 1'b1;
                w_next_ptr = PW'(((int'(r_ptr) + i) % N + 1) % N);
            end
        end
    end

    // The pointer moves past the winner only when the grant is actually consumed.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_ptr <= '0;
        end else if (advance && w_found) begin
            r_ptr <= w_next_ptr;
        end
    end

endmodule

// File: rtl/tcu_priv_pmpfail_collect.sv
// tcu_priv_pmpfail_collect: captures per-source PMP failures and feeds them one at a time to the core-request unit
module tcu_priv_pmpfail_collect
    import tcu_priv_pmpfail_collect_pkg::*;
#(
    parameter int NUM_SRC       = 2,
    parameter int DROP_CNT_SIZE = 16
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    input  logic [NUM_SRC-1:0]                     src_fail_i,
    input  logic [NUM_SRC*TCU_PHYSADDR_SIZE-1:0]   src_addr_i,
    input  logic [NUM_SRC-1:0]                     src_write_i,
    input  logic [NUM_SRC*TCU_ERROR_SIZE-1:0]      src_error_i,
    input  logic                                   dedup_clr_i,
    output logic                                   pmpfail_push_o,
    output logic [TCU_CORE_REQ_PMPFAIL_SIZE-1:0]   pmpfail_data_o,
    input  logic                                   pmpfail_stall_i,
    output logic [DROP_CNT_SIZE-1:0]               drop_cnt_o,
    output logic                                   overflow_o,
    output logic                                   busy_o
);

    logic [NUM_SRC-1:0]     r_slot_vld;
    pmpfail_t               r_slot_data [NUM_SRC];
    logic                   r_out_vld;
    pmpfail_t               r_out_data;
    logic                   r_rec_vld;
    pmpfail_t               r_rec_data;
    logic [DROP_CNT_SIZE-1:0] r_drop_cnt;
    logic                   r_overflow;

    pmpfail_t               w_src_data [NUM_SRC];
    logic [NUM_SRC-1:0]     w_gnt_raw;
    logic [NUM_SRC-1:0]     w_gnt;
    logic [NUM_SRC-1:0]     w_cap;
    logic [NUM_SRC-1:0]     w_drop;
    pmpfail_t               w_gnt_data;
    logic                   w_out_free;
    logic                   w_xfer;
    logic [DROP_CNT_SIZE:0] w_sum;

    tcu_rr_arbiter #(.N(NUM_SRC)) u_arb (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .req          (r_slot_vld),
        .advance      (w_out_free),
        .grant_onehot (w_gnt_raw)
    );

    // Per-source dedup, capture/drop decisions, granted-data mux and saturating drop sum.
    always_comb begin
        w_out_free = !r_out_vld || !pmpfail_stall_i;
        w_xfer     = r_out_vld && !pmpfail_stall_i;
        w_gnt      = '0;
        w_cap      = '0;
        w_drop     = '0;
        w_gnt_data = '0;
        w_sum      = {1'b0, r_drop_cnt};
        for (int n = 0; n < NUM_SRC; n++) begin
            w_src_data[n] = pack_pmpfail(src_addr_i[n*TCU_PHYSADDR_SIZE +: TCU_PHYSADDR_SIZE],
                                         src_error_i[n*TCU_ERROR_SIZE +: TCU_ERROR_SIZE],
                                         src_write_i[n]);
            w_gnt[n]   = w_gnt_raw[n] && w_out_free;
            w_cap[n]   = src_fail_i[n] && !(r_rec_vld && r_rec_data == w_src_data[n])
                         && (!r_slot_vld[n] || w_gnt[n]);
            w_drop[n]  = src_fail_i[n] && !(r_rec_vld && r_rec_data == w_src_data[n])
                         && r_slot_vld[n] && !w_gnt[n];
            w_gnt_data = w_gnt_data | (w_gnt[n] ? r_slot_data[n] : '0);
            w_sum      = w_sum + (DROP_CNT_SIZE+1)'(w_drop[n]);
        end
    end

    // Capture slots: a refill in the same cycle as a grant keeps the slot valid.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_slot_vld <= '0;
            for (int n = 0; n < NUM_SRC; n++) r_slot_data[n] <= '0;
        end else begin
            for (int n = 0; n < NUM_SRC; n++) begin
                if (w_cap[n]) begin
                    r_slot_vld[n]  <= 1'b1;
                    r_slot_data[n] <= w_src_data[n];
                end else if (w_gnt[n]) begin
                    r_slot_vld[n]  <= 1'b0;
                end
            end
        end
    end

    // Output register: reloads with the next grant (or empties) whenever it is free.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_out_vld  <= 1'b0;
            r_out_data <= '0;
        end else if (w_out_free) begin
            r_out_vld  <= |w_gnt;
            r_out_data <= w_gnt_data;
        end
    end

    // Last-pushed record; a completed transfer wins over a concurrent clear.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_rec_vld  <= 1'b0;
            r_rec_data <= '0;
        end else if (w_xfer) begin
            r_rec_vld  <= 1'b1;
            r_rec_data <= r_out_data;
        end else if (dedup_clr_i) begin
            r_rec_vld  <= 1'b0;
        end
    end

    // Drop statistics persist until reset; the counter saturates at all-ones.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_drop_cnt <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_drop_cnt <= w_sum[DROP_CNT_SIZE] ? '1 : w_sum[DROP_CNT_SIZE-1:0];
            r_overflow <= r_overflow || (|w_drop);
        end
    end

    assign pmpfail_push_o = r_out_vld;
    assign pmpfail_data_o = r_out_data;
    assign drop_cnt_o     = r_drop_cnt;
    assign overflow_o     = r_overflow;
    assign busy_o         = (|r_slot_vld) || r_out_vld;

endmodule

// File: tb/tb_tcu_priv_pmpfail_collect.sv
// tb_tcu_priv_pmpfail_collect: directed self-checking bench for the PMP-failure collector
module tb_tcu_priv_pmpfail_collect;
    import tcu_priv_pmpfail_collect_pkg::*;

    localparam int A = TCU_PHYSADDR_SIZE;
    localparam int E = TCU_ERROR_SIZE;
    localparam int D = TCU_CORE_REQ_PMPFAIL_SIZE;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [1:0]     src_fail = '0;
    logic [2*A-1:0] src_addr = '0;
    logic [1:0]     src_write = '0;
    logic [2*E-1:0] src_error = '0;
    logic           dedup_clr = 1'b0;
    logic           push;
    logic [D-1:0]   data;
    logic           stall = 1'b0;
    logic [15:0]    drop_cnt;
    logic           overflow;
    logic           busy;

    int n_tests = 0;
    int n_fail  = 0;

    tcu_priv_pmpfail_collect #(.NUM_SRC(2), .DROP_CNT_SIZE(16)) dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n),
        .src_fail_i      (src_fail),
        .src_addr_i      (src_addr),
        .src_write_i     (src_write),
        .src_error_i     (src_error),
        .dedup_clr_i     (dedup_clr),
        .pmpfail_push_o  (push),
        .pmpfail_data_o  (data),
        .pmpfail_stall_i (stall),
        .drop_cnt_o      (drop_cnt),
        .overflow_o      (overflow),
        .busy_o          (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int n, input logic [A-1:0] addr, input logic [E-1:0] err, input logic wr);
        src_fail[n]         = 1'b1;
        src_addr[n*A +: A]  = addr;
        src_error[n*E +: E] = err;
        src_write[n]        = wr;
    endtask

    task automatic expect_push(input string name, input logic [D-1:0] exp);
        n_tests++;
        if (push !== 1'b1 || data !== exp) begin
            n_fail++;
            $display("FAIL %s: push=%0b data=%h, required push=1 data=%h", name, push, data, exp);
        end
    endtask

    task automatic expect_idle(input string name);
        n_tests++;
        if (push !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: push=%0b, required 0", name, push);
        end
    endtask

    task automatic expect_stats(input string name, input logic [15:0] cnt, input logic ovf);
        n_tests++;
        if (drop_cnt !== cnt || overflow !== ovf) begin
            n_fail++;
            $display("FAIL %s: drop_cnt=%0d overflow=%0b, required %0d/%0b", name, drop_cnt, overflow, cnt, ovf);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        tick();
        n_tests++;
        if (push !== 1'b0 || data !== '0 || drop_cnt !== '0 || overflow !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: push=%0b data=%h drop=%0d ovf=%0b busy=%0b, required all 0",
                     push, data, drop_cnt, overflow, busy);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        strobe(0, 32'h1000, 5'd5, 1'b1);
        tick();
        src_fail = '0;
        expect_idle("single_t1");
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_busy: busy=%0b, required 1", busy);
        end
        tick();
        expect_push("single_t2", {32'h1000, 5'd5, 1'b1});
        tick();
        expect_idle("single_t3");
        expect_stats("single_stats", 16'd0, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_reset();
        strobe(0, 32'hA0, 5'd1, 1'b0);
        strobe(1, 32'hB0, 5'd2, 1'b1);
        tick();
        src_fail = '0;
        tick();
        expect_push("b2b_first", {32'hA0, 5'd1, 1'b0});
        tick();
        expect_push("b2b_second", {32'hB0, 5'd2, 1'b1});
        tick();
        expect_idle("b2b_done");
        strobe(0, 32'hC0, 5'd1, 1'b0);
        strobe(1, 32'hD0, 5'd2, 1'b0);
        tick();
        src_fail = '0;
        tick();
        expect_push("b2b_ptr_wrap_first", {32'hC0, 5'd1, 1'b0});
        tick();
        expect_push("b2b_ptr_wrap_second", {32'hD0, 5'd2, 1'b0});
        tick();
        expect_idle("b2b_ptr_wrap_done");
    endtask

    task automatic test_stall_drop();
        stall = 1'b1;
        strobe(1, 32'h300, 5'd7, 1'b1);
        tick();
        src_fail = '0;
        tick();
        expect_push("stall_head", {32'h300, 5'd7, 1'b1});
        for (int i = 0; i < 10; i++) begin
            if (i < 3) strobe(1, 32'h310 + 32'(i * 16), 5'd4, 1'b0);
            else src_fail = '0;
            tick();
            expect_push($sformatf("stall_hold_%0d", i), {32'h300, 5'd7, 1'b1});
        end
        expect_stats("stall_drops", 16'd2, 1'b1);
        strobe(0, 32'h340, 5'd6, 1'b1);
        tick();
        strobe(0, 32'h350, 5'd6, 1'b1);
        strobe(1, 32'h360, 5'd6, 1'b1);
        tick();
        src_fail = '0;
        expect_stats("dual_drop", 16'd4, 1'b1);
        stall = 1'b0;
        tick();
        expect_push("drain_slot0", {32'h340, 5'd6, 1'b1});
        tick();
        expect_push("drain_slot1", {32'h310, 5'd4, 1'b0});
        tick();
        expect_idle("drain_done");
    endtask

    task automatic test_dedup();
        strobe(0, 32'h2000, 5'd3, 1'b0);
        tick();
        src_fail = '0;
        tick();
        expect_push("dedup_first", {32'h2000, 5'd3, 1'b0});
        tick();
        expect_idle("dedup_first_done");
        strobe(0, 32'h2000, 5'd3, 1'b0);
        tick();
        src_fail = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_idle($sformatf("dedup_suppressed_%0d", i));
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL dedup_busy: busy=%0b, required 0", busy);
        end
        expect_stats("dedup_not_counted", 16'd4, 1'b1);
        dedup_clr = 1'b1;
        tick();
        dedup_clr = 1'b0;
        strobe(0, 32'h2000, 5'd3, 1'b0);
        tick();
        src_fail = '0;
        tick();
        expect_push("dedup_after_clr", {32'h2000, 5'd3, 1'b0});
        tick();
        expect_idle("dedup_after_clr_done");
        expect_stats("dedup_stats_persist", 16'd4, 1'b1);
    endtask

    task automatic test_async_reset();
        stall = 1'b1;
        strobe(0, 32'h500, 5'd1, 1'b1);
        tick();
        src_fail = '0;
        tick();
        expect_push("areset_setup", {32'h500, 5'd1, 1'b1});
        strobe(0, 32'h510, 5'd1, 1'b1);
        strobe(1, 32'h520, 5'd1, 1'b1);
        tick();
        src_fail = '0;
        #2;
        reset_n = 1'b0;
        #1;
        n_tests++;
        if (push !== 1'b0 || data !== '0 || drop_cnt !== '0 || overflow !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: push=%0b data=%h drop=%0d ovf=%0b busy=%0b, required all 0",
                     push, data, drop_cnt, overflow, busy);
        end
        stall = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_idle($sformatf("post_reset_%0d", i));
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_busy: busy=%0b, required 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall_drop();
        test_dedup();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
